// File: rtl/shift_collect.sv
// shift_collect: MSB-first serial-to-parallel collector with one-entry valid/ready buffer; SHIFT_COLLECT_PARITY_EN adds a parity bit
module shift_collect #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             resetq,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             frame_start,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_cnt,
  output logic             overflow,
  output logic             resync
`ifdef SHIFT_COLLECT_PARITY_EN
  ,
  output logic             parity_err
`endif
);
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  state_t state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, word_q, word_d, done_word, shifted, fresh;
  logic [CW-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d, ovf_q, ovf_d, resync_q, resync_d, done, load;
`ifdef SHIFT_COLLECT_PARITY_EN
  logic perr_q, perr_d;
`endif
  assign shifted = {shreg_q[WIDTH-2:0], bit_in};
  assign fresh = {{(WIDTH-1){1'b0}}, bit_in};
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d = cnt_q;
    resync_d = 1'b0;
    done = 1'b0;
    done_word = shifted;
`ifdef SHIFT_COLLECT_PARITY_EN
    perr_d = perr_q;
`endif
    if (bit_valid && frame_start) begin
      state_d = SHIFT;
      shreg_d = fresh;
      cnt_d = CW'(1);
      resync_d = state_q != IDLE;
    end else if (bit_valid && state_q == SHIFT) begin
      shreg_d = shifted;
      cnt_d = cnt_q == LAST ? '0 : cnt_q + 1'b1;
      if (cnt_q == LAST) begin
`ifdef SHIFT_COLLECT_PARITY_EN
        state_d = PARITY;
`else
        state_d = IDLE;
        done = 1'b1;
`endif
      end
`ifdef SHIFT_COLLECT_PARITY_EN
    end else if (bit_valid && state_q == PARITY) begin
      state_d = IDLE;
      done = 1'b1;
      done_word = shreg_q;
      perr_d = perr_q | (^{shreg_q, bit_in});
`endif
    end
    load = done && (!valid_q || word_ready);
    word_d = load ? done_word : word_q;
    valid_d = load | (valid_q & ~word_ready);
    ovf_d = ovf_q | (done & ~load);
  end
  always_ff @(posedge clk) begin
    if (!resetq) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q <= '0;
      word_q <= '0;
      valid_q <= 1'b0;
      ovf_q <= 1'b0;
      resync_q <= 1'b0;
`ifdef SHIFT_COLLECT_PARITY_EN
      perr_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q <= cnt_d;
      word_q <= word_d;
      valid_q <= valid_d;
      ovf_q <= ovf_d;
      resync_q <= resync_d;
`ifdef SHIFT_COLLECT_PARITY_EN
      perr_q <= perr_d;
`endif
    end
  end
  assign word_out = word_q;
  assign word_valid = valid_q;
  assign bit_cnt = cnt_q;
  assign overflow = ovf_q;
  assign resync = resync_q;
`ifdef SHIFT_COLLECT_PARITY_EN
  assign parity_err = perr_q;
`endif
endmodule

// File: tb/tb_shift_collect.sv
// tb_shift_collect: directed and random stimulus against a bit-list reference model with a word scoreboard
module tb_shift_collect;
  localparam int W = 8;
  localparam int CW = $clog2(W + 1);
`ifdef SHIFT_COLLECT_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  logic clk = 1'b0, resetq = 1'b0, bit_in = 1'b0, bit_valid = 1'b0, frame_start = 1'b0, word_ready = 1'b0;
  logic [W-1:0] word_out;
  logic word_valid, overflow, resync;
  logic [CW-1:0] bit_cnt;
`ifdef SHIFT_COLLECT_PARITY_EN
  logic parity_err;
`endif
  shift_collect #(.WIDTH(W)) dut (
    .clk(clk), .resetq(resetq), .bit_in(bit_in), .bit_valid(bit_valid), .frame_start(frame_start),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready), .bit_cnt(bit_cnt),
    .overflow(overflow), .resync(resync)
`ifdef SHIFT_COLLECT_PARITY_EN
    , .parity_err(parity_err)
`endif
  );
  always #5 clk = ~clk;
  bit m_bits[$];
  bit m_full, m_ovf, m_resync, m_perr;
  logic [W-1:0] sb[$];
  int passed = 0, total = 0, resync_seen = 0;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    else passed++;
  endtask
  always @(posedge clk) begin : model
    logic [W-1:0] w;
    bit par, done;
    if (!resetq) begin
      m_bits.delete();
      sb.delete();
      m_full = 0;
      m_ovf = 0;
      m_resync = 0;
      m_perr = 0;
    end else begin
      done = 0;
      m_resync = 0;
      w = '0;
      if (bit_valid) begin
        if (frame_start) begin
          m_resync = m_bits.size() > 0;
          m_bits.delete();
          m_bits.push_back(bit_in);
        end else if (m_bits.size() > 0) begin
          m_bits.push_back(bit_in);
          if (m_bits.size() == NB) begin
            par = 0;
            foreach (m_bits[i]) begin
              par ^= m_bits[i];
              if (i < W) w = {w[W-2:0], m_bits[i]};
            end
            if (NB > W && par) m_perr = 1;
            done = 1;
            m_bits.delete();
          end
        end
      end
      if (done && (!m_full || word_ready)) begin
        sb.push_back(w);
        m_full = 1;
      end else begin
        if (done) m_ovf = 1;
        if (word_ready) m_full = 0;
      end
    end
  end
  always @(negedge clk) begin : monitor
    chk("bit_cnt", 32'(bit_cnt), m_bits.size() >= W ? 0 : m_bits.size());
    chk("word_valid", 32'(word_valid), 32'(m_full));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("resync", 32'(resync), 32'(m_resync));
`ifdef SHIFT_COLLECT_PARITY_EN
    chk("parity_err", 32'(parity_err), 32'(m_perr));
`endif
    if (resync === 1'b1) resync_seen++;
    if (word_valid && word_ready) begin
      if (sb.size() == 0) begin
        total++;
        $display("FAIL sb_empty: word %0h handed over, none expected", word_out);
      end else chk("word_out", 32'(word_out), 32'(sb.pop_front()));
    end
  end
  task automatic drive(input logic b, input logic fs);
    bit_valid = 1'b1;
    bit_in = b;
    frame_start = fs;
    @(posedge clk);
    #1;
    bit_valid = 1'b0;
    frame_start = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [W-1:0] w, input bit bad = 0, input int last_rdy = -1);
    for (int i = 0; i < NB; i++) begin
      if (i == NB - 1 && last_rdy >= 0) word_ready = 1'(last_rdy);
      drive(i < W ? w[W-1-i] : (^w) ^ bad, i == 0);
    end
  endtask
  task automatic do_reset();
    resetq = 1'b0;
    idle(1);
    resetq = 1'b1;
  endtask
  initial begin
    int r0;
    idle(2);
    chk("rst_word", 32'(word_out), 0);
    chk("rst_valid", 32'(word_valid), 0);
    resetq = 1'b1;
    word_ready = 1'b1;
    send(8'hA5);
    chk("a5_word", 32'(word_out), 32'hA5);
    chk("a5_valid", 32'(word_valid), 1);
    idle(1);
    chk("a5_drop", 32'(word_valid), 0);
    word_ready = 1'b0;
    send(8'h12);
    send(8'h34);
    chk("ovf_word", 32'(word_out), 32'h12);
    chk("ovf_flag", 32'(overflow), 1);
    word_ready = 1'b1;
    idle(2);
    do_reset();
    word_ready = 1'b0;
    send(8'h12);
    send(8'h34, 0, 1);
    chk("repl_word", 32'(word_out), 32'h34);
    chk("repl_valid", 32'(word_valid), 1);
    chk("repl_ovf", 32'(overflow), 0);
    idle(2);
    r0 = resync_seen;
    drive(1'b1, 1'b1);
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    send(8'h3C);
    chk("rs_word", 32'(word_out), 32'h3C);
    idle(2);
    chk("rs_pulses", 32'(resync_seen - r0), 1);
    for (int i = 0; i < 5; i++) drive(1'b1, i == 0);
    do_reset();
    chk("rst_cnt", 32'(bit_cnt), 0);
    send(8'hFF);
    chk("ff_word", 32'(word_out), 32'hFF);
    idle(2);
`ifdef SHIFT_COLLECT_PARITY_EN
    do_reset();
    send(8'h01);
    chk("par_ok", 32'(parity_err), 0);
    send(8'h01, 1);
    chk("par_word", 32'(word_out), 32'h01);
    chk("par_err", 32'(parity_err), 1);
    idle(2);
`endif
    repeat (3000) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      word_ready = 1'($urandom);
      bit_valid = $urandom_range(0, 9) < 7;
      bit_in = 1'($urandom);
      frame_start = bit_valid && (m_bits.size() == 0 ? $urandom_range(0, 2) != 0 : $urandom_range(0, 24) == 0);
      @(posedge clk);
      #1;
    end
    bit_valid = 1'b0;
    frame_start = 1'b0;
    word_ready = 1'b1;
    idle(3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
